// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU opcode constants and legality check
package alu_arbiter_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SLL = 4'd1;
  localparam logic [3:0] ALU_SLT = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_AND = 4'd7;
  localparam logic [3:0] ALU_SUB = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd13;
  localparam logic [3:0] ALU_MUL = 4'd15;

  function automatic logic alu_sel_legal(input logic [3:0] sel);
    case (sel)
      ALU_ADD, ALU_SLL, ALU_SLT, ALU_XOR, ALU_SRL,
      ALU_OR, ALU_AND, ALU_SUB, ALU_SRA, ALU_MUL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational 32-bit ALU with illegal-opcode flag
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [3:0]      sel,
  output logic [XLEN-1:0] result,
  output logic            err
);

  logic [4:0] shamt;
  assign shamt = rs2[4:0];

  // Illegal codes fall into the default arm so result is 0 whenever err is set.
  always_comb begin
    result = '0;
    err    = !alu_sel_legal(sel);
    case (sel)
      ALU_ADD: result = rs1 + rs2;
      ALU_SLL: result = rs1 << shamt;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      ALU_XOR: result = rs1 ^ rs2;
      ALU_SRL: result = rs1 >> shamt;
      ALU_OR:  result = rs1 | rs2;
      ALU_AND: result = rs1 & rs2;
      ALU_SUB: result = rs1 - rs2;
      ALU_SRA: result = $unsigned($signed(rs1) >>> shamt);
      ALU_MUL: result = rs1 * rs2;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU with a registered tagged response
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [XLEN*NUM_REQ-1:0] req_rs1,
  input  logic [XLEN*NUM_REQ-1:0] req_rs2,
  input  logic [4*NUM_REQ-1:0]    req_sel,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [XLEN-1:0]         rsp_data,
  output logic                    rsp_err
);

  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [XLEN-1:0]      rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  logic [(1<<ID_W)-1:0] valid_pad;
  logic [ID_W-1:0]      scan_idx;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_found;
  logic                 can_accept;
  logic                 accept;
  logic [NUM_REQ-1:0]   ready_vec;
  logic [XLEN-1:0]      mux_rs1, mux_rs2, alu_result;
  logic [3:0]           mux_sel;
  logic                 alu_err;

  assign can_accept = !rsp_valid_q || rsp_ready;

  // Walk the requesters from rr_ptr, wrapping at NUM_REQ, first valid wins.
  always_comb begin
    valid_pad              = '0;
    valid_pad[NUM_REQ-1:0] = req_valid;
    grant_found            = 1'b0;
    grant_idx              = '0;
    scan_idx               = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && valid_pad[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
      scan_idx = (scan_idx == ID_W'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  always_comb begin
    mux_rs1   = '0;
    mux_rs2   = '0;
    mux_sel   = '0;
    ready_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        mux_rs1      = req_rs1[XLEN*i +: XLEN];
        mux_rs2      = req_rs2[XLEN*i +: XLEN];
        mux_sel      = req_sel[4*i +: 4];
        ready_vec[i] = grant_found && can_accept && rst_n;
      end
    end
  end

  assign accept    = |ready_vec;
  assign req_ready = ready_vec;

  alu_arbiter_alu u_alu (
    .rs1    (mux_rs1),
    .rs2    (mux_rs2),
    .sel    (mux_sel),
    .result (alu_result),
    .err    (alu_err)
  );

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx;
      rsp_data_d  = alu_result;
      rsp_err_d   = alu_err;
      rr_ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_rs1;
  logic [63:0] req_rs2;
  logic [7:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(2), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    req_sel[4*i +: 4]  = sel;
    req_rs1[32*i +: 32] = a;
    req_rs2[32*i +: 32] = b;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                         input logic [31:0] d, input logic e);
    chk({tag, "_valid"}, {31'b0, rsp_valid}, {31'b0, v});
    chk({tag, "_id"},    {30'b0, rsp_id},    {30'b0, id});
    chk({tag, "_data"},  rsp_data,           d);
    chk({tag, "_err"},   {31'b0, rsp_err},   {31'b0, e});
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_rs1   = '0;
    req_rs2   = '0;
    req_sel   = '0;
    rsp_ready = 1'b1;
    #1;
    chk("reset_ready", {30'b0, req_ready}, 32'd0);
    cyc();
    cyc();
    chk_rsp("reset", 1'b0, 2'd0, 32'd0, 1'b0);
    req_valid = 2'b00;
    rst_n     = 1'b1;
    cyc();

    // single request, ADD 5+7
    set_req(0, 4'd0, 32'd5, 32'd7);
    req_valid = 2'b01;
    #1;
    chk("single_ready", {30'b0, req_ready}, 32'd1);
    cyc();
    req_valid = 2'b00;
    chk_rsp("single", 1'b1, 2'd0, 32'd12, 1'b0);
    cyc();
    chk("drain_valid", {31'b0, rsp_valid}, 32'd0);

    // illegal opcode on req1 (pointer is 1 here)
    set_req(1, 4'd3, 32'd1, 32'd1);
    req_valid = 2'b10;
    #1;
    chk("illegal_ready", {30'b0, req_ready}, 32'd2);
    cyc();
    chk_rsp("illegal", 1'b1, 2'd1, 32'd0, 1'b1);

    // round robin with both valid, pointer back at 0
    set_req(0, 4'd4, 32'h0000_00F0, 32'h0000_000F);
    set_req(1, 4'd8, 32'd3, 32'd5);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready", {30'b0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      cyc();
      chk("rr_id",   {30'b0, rsp_id}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_data", rsp_data, (k % 2 == 0) ? 32'h0000_00FF : 32'hFFFF_FFFE);
    end

    // backpressure: response held, req1 waiting with SRA
    set_req(1, 4'd13, 32'h8000_0000, 32'h0000_0021);
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", {30'b0, req_ready}, 32'd0);
      cyc();
      chk_rsp("bp_hold", 1'b1, 2'd1, 32'hFFFF_FFFE, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {30'b0, req_ready}, 32'd2);
    cyc();
    chk_rsp("sra", 1'b1, 2'd1, 32'hC000_0000, 1'b0);

    // drain-and-accept back to back
    set_req(0, 4'd15, 32'h0001_0000, 32'h0001_0000);
    req_valid = 2'b01;
    #1;
    chk("mul_ready", {30'b0, req_ready}, 32'd1);
    cyc();
    chk_rsp("mul", 1'b1, 2'd0, 32'd0, 1'b0);

    set_req(1, 4'd2, 32'hFFFF_FFFF, 32'd1);
    req_valid = 2'b10;
    cyc();
    chk_rsp("slt_big", 1'b1, 2'd1, 32'd0, 1'b0);

    set_req(0, 4'd2, 32'd1, 32'hFFFF_FFFF);
    req_valid = 2'b01;
    cyc();
    chk_rsp("slt_small", 1'b1, 2'd0, 32'd1, 1'b0);

    set_req(1, 4'd5, 32'h8000_0000, 32'h0000_0024);
    req_valid = 2'b10;
    cyc();
    chk_rsp("srl", 1'b1, 2'd1, 32'h0800_0000, 1'b0);

    set_req(0, 4'd6, 32'hF0F0_0000, 32'h0000_0F0F);
    req_valid = 2'b01;
    cyc();
    chk_rsp("or", 1'b1, 2'd0, 32'hF0F0_0F0F, 1'b0);

    // reset mid-operation with pointer at 1 and both requesting
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("midrst_ready", {30'b0, req_ready}, 32'd0);
    cyc();
    chk("midrst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_data",  rsp_data, 32'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("postrst_ready", {30'b0, req_ready}, 32'd1);
    cyc();
    chk_rsp("postrst", 1'b1, 2'd0, 32'hF0F0_0F0F, 1'b0);
    req_valid = 2'b00;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU datapath instance between NUM_REQ requesters, e.g. the integer pipeline, the address-generation unit and a debug/test port.
- Uses round-robin arbitration with valid/ready handshakes on each request port.
- Has a single registered response stage tagged with the requester ID.
- Flags opcodes outside the supported ALU set.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- ID_W, 2, width of the requester ID tag; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_rs1  in  32*NUM_REQ  operand A, requester i at bits [32i+31:32i]
- req_rs2  in  32*NUM_REQ  operand B, same packing
- req_sel  in  4*NUM_REQ  ALU opcode, requester i at bits [4i+3:4i]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  ID_W  index of the requester that owns the response
- rsp_data  out  32  ALU result
- rsp_err  out  1  opcode was not in the supported set; rsp_data is 0

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready forced to all-zero while rst_n=0.
- Reset mid-operation: a held response is discarded, and no request is accepted in the reset cycle.
- Supported opcodes: ADD=0, SLL=1, SLT=2, XOR=4, SRL=5, OR=6, AND=7, SUB=8, SRA=13, MUL=15.
  - Any other code sets rsp_err=1 and rsp_data=0.
- ALU arithmetic and widths:
  - Shifts use rs2[4:0].
  - SLT is an unsigned compare and returns 1 or 0.
  - MUL returns the low 32 bits of the product.
  - ADD and SUB wrap modulo 2^32.
- can_accept = !rsp_valid | rsp_ready.
- Grant logic (combinational):
  - Scan req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit wins.
  - req_ready[g] = can_accept & req_valid[g]; all other ready bits are 0.
- Accept (req_valid[g] & req_ready[g]):
  - Mux requester g's operands and opcode into the ALU.
  - Register the ALU result into rsp_data, g into rsp_id, and the error flag into rsp_err; set rsp_valid=1.
  - rr_ptr <= (g+1) mod NUM_REQ. rr_ptr is unchanged when nothing is accepted.
- Latency and throughput:
  - 1 cycle from accept to rsp_valid.
  - Throughput is 1 accept per cycle while rsp_ready=1.
- Backpressure:
  - While rsp_valid=1 and rsp_ready=0, all req_ready=0.
  - rsp_id, rsp_data and rsp_err hold stable.
- Simultaneous drain and accept (rsp_ready=1 with a new accept in the same cycle): the response register is overwritten with the new result, rsp_valid stays 1, and no bubble is inserted.
- Drain with no new request: rsp_valid <= 0 on the next cycle.
- Requester protocol:
  - Once req_valid is asserted, it and its payload stay stable until ready.
  - The arbiter does not itself depend on this rule; a dropped request simply loses arbitration.
- Fairness: a continuously requesting port is granted within NUM_REQ accepts.
- Index wrap: rr_ptr wraps from NUM_REQ-1 to 0. With NUM_REQ not a power of two, pointer values >= NUM_REQ are unreachable.

Decomposition:
- Shared package holds:
  - ALU opcode constants (ALU_ADD..ALU_MUL).
  - A function alu_sel_legal(sel) returning 1 for the ten supported codes.
  - The result width constant XLEN=32.
- Natural sub-module: the team's existing ALU module, instantiated once inside alu_arbiter and driven by the granted operand mux.
- Arbitration, the operand mux and the response register stay in alu_arbiter itself.

Test Plan:
- Single request: reset, then req0 ADD rs1=5 rs2=7 with rsp_ready=1. Expect req_ready[0]=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=12, rsp_err=0.
- Round-robin: both requesters valid continuously for 4 cycles, req0 XOR 0xF0^0x0F, req1 SUB 3-5, rsp_ready=1. Expect rsp_id sequence 0,1,0,1 with data 0xFF, 0xFFFFFFFE, 0xFF, 0xFFFFFFFE.
- Backpressure: a response is held with rsp_ready=0 for 3 cycles while req1 is valid. Expect req_ready=0, rsp_* stable, rr_ptr unchanged. Raise rsp_ready: req1 is accepted that cycle, and the next response appears with no bubble.
- Illegal opcode: req1 sel=3, rs1=rs2=1. Expect rsp_err=1, rsp_data=0, rsp_id=1.
- Shift and MUL corners:
  - SRA 0x80000000 by rs2=0x21 gives 0xC0000000 (shift amount 1).
  - MUL 0x10000 * 0x10000 gives 0.
  - SLT 0xFFFFFFFF < 1 gives 0.
- Reset mid-operation: assert rst_n=0 while rsp_valid=1 and requests are pending. Next cycle expect rsp_valid=0, req_ready=0; after release, the first grant goes to req0.
